// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one word at a time, holds it for decode and picks the next PC.
// Latency: 3 cycles per instruction minimum (request accepted, one-cycle response, immediate consume).
// Backpressure: a held instruction stays put until consume; the request address stays put until imemReady.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             imemReq,
    output logic [31:0]      imemAddr,
    input  logic             imemReady,
    input  logic             imemRspValid,
    input  logic [31:0]      imemRspData,
    output logic [31:0]      instr,
    output logic [5:0]       opCode,
    output logic             instrValid,
    input  logic             consume,
    input  logic             jump,
    input  logic             Branch,
    input  logic             zero,
    output logic [31:0]      pcOut,
    output logic [31:0]      pcPlus4,
    output logic [CNT_W-1:0] fetchCount
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [31:0]      pc;
    logic [31:0]      pcNext;
    logic [31:0]      instrQ;
    logic [31:0]      branchOff;
    logic [CNT_W-1:0] cnt;
    logic             retire;
    logic             rspTake;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_REQ;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_REQ:  if (imemReady)    nextState = ST_WAIT;
            ST_WAIT: if (imemRspValid) nextState = ST_FULL;
            ST_FULL: if (consume)      nextState = ST_REQ;
            default:                   nextState = ST_REQ;
        endcase
    end

    always_comb begin
        imemReq    = (state == ST_REQ);
        instrValid = (state == ST_FULL);
        retire     = (state == ST_FULL) && consume;
        rspTake    = (state == ST_WAIT) && imemRspValid;
    end

    // Control inputs only matter on the retiring cycle, so no qualification is needed here.
    always_comb begin
        pcPlus4   = pc + 32'd4;
        branchOff = {{14{instrQ[15]}}, instrQ[15:0], 2'b00};
        if (jump) begin
            pcNext = {pcPlus4[31:28], instrQ[25:0], 2'b00};
        end else if (Branch && zero) begin
            pcNext = pcPlus4 + branchOff;
        end else begin
            pcNext = pcPlus4;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc     <= RESET_PC;
            instrQ <= 32'd0;
            cnt    <= '0;
        end else begin
            if (rspTake) begin
                instrQ <= imemRspData;
            end
            if (retire) begin
                pc  <= pcNext;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign imemAddr   = pc;
    assign pcOut      = pc;
    assign instr      = instrQ;
    assign opCode     = instrQ[31:26];
    assign fetchCount = cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a next-PC reference model.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        imemReady = 1'b0;
    logic        imemRspValid = 1'b0;
    logic [31:0] imemRspData = 32'd0;
    logic        consume = 1'b0;
    logic        jump = 1'b0;
    logic        Branch = 1'b0;
    logic        zero = 1'b0;

    logic        imemReq, instrValid;
    logic [31:0] imemAddr, instr, pcOut, pcPlus4;
    logic [5:0]  opCode;
    logic [15:0] fetchCount;

    logic        imemReqB, instrValidB;
    logic [31:0] imemAddrB, instrB, pcOutB, pcPlus4B;
    logic [5:0]  opCodeB;
    logic [1:0]  fetchCountB;

    int nChecks = 0;
    int nFails  = 0;

    always #5 CLK = ~CLK;

    instr_fetch_unit u_dut (
        .CLK(CLK), .RST(RST), .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData), .instr(instr), .opCode(opCode),
        .instrValid(instrValid), .consume(consume), .jump(jump), .Branch(Branch), .zero(zero),
        .pcOut(pcOut), .pcPlus4(pcPlus4), .fetchCount(fetchCount)
    );

    // Second instance runs in lockstep; its reset PC reaches the upper address region and its narrow counter wraps quickly.
    instr_fetch_unit #(.RESET_PC(32'h3000_0008), .CNT_W(2)) u_dutB (
        .CLK(CLK), .RST(RST), .imemReq(imemReqB), .imemAddr(imemAddrB), .imemReady(imemReady),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData), .instr(instrB), .opCode(opCodeB),
        .instrValid(instrValidB), .consume(consume), .jump(jump), .Branch(Branch), .zero(zero),
        .pcOut(pcOutB), .pcPlus4(pcPlus4B), .fetchCount(fetchCountB)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] w,
                                            input logic j, input logic b, input logic z);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        if (b && z) begin
            off = $signed(w[15:0]);
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic idleInputs();
        imemReady = 0; imemRspValid = 0; imemRspData = 0;
        consume = 0; jump = 0; Branch = 0; zero = 0;
    endtask

    task automatic doReset();
        RST = 0;
        idleInputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1;
    endtask

    task automatic doFetch(input logic [31:0] word, output logic [31:0] addr, output bit ok);
        int n = 0;
        ok = 0;
        addr = 32'hxxxx_xxxx;
        while (imemReq !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (imemReq !== 1'b1) return;
        addr = imemAddr;
        imemReady = 1;
        @(negedge CLK);
        imemReady = 0;
        imemRspValid = 1;
        imemRspData = word;
        @(negedge CLK);
        imemRspValid = 0;
        imemRspData = 0;
        ok = 1;
    endtask

    task automatic doRetire(input logic j, input logic b, input logic z);
        consume = 1; jump = j; Branch = b; zero = z;
        @(negedge CLK);
        consume = 0; jump = 0; Branch = 0; zero = 0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nChecks++;
        if ({imemReq, imemAddr, instrValid, instr, fetchCount, pcPlus4} !== {1'b1, 32'd0, 1'b0, 32'd0, 16'd0, 32'd4}) begin
            nFails++;
            $display("FAIL reset_state: req=%b addr=%h vld=%b instr=%h cnt=%0d pc4=%h, want 1 0 0 0 0 4",
                     imemReq, imemAddr, instrValid, instr, fetchCount, pcPlus4);
        end
        RST = 1;
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        bit ok;
        doFetch(32'h2008_0005, a, ok);
        nChecks++;
        if (!ok || a !== 32'd0) begin
            nFails++;
            $display("FAIL first_addr: ok=%b addr=%h, want addr 0", ok, a);
        end
        nChecks++;
        if ({instrValid, opCode, pcOut, pcPlus4, instr} !== {1'b1, 6'b001000, 32'd0, 32'd4, 32'h2008_0005}) begin
            nFails++;
            $display("FAIL first_hold: vld=%b op=%b pc=%h pc4=%h instr=%h, want 1 001000 0 4 20080005",
                     instrValid, opCode, pcOut, pcPlus4, instr);
        end
        doRetire(0, 0, 0);
        nChecks++;
        if ({imemReq, imemAddr} !== {1'b1, 32'd4}) begin
            nFails++;
            $display("FAIL latency3: req=%b addr=%h, want 1 00000004", imemReq, imemAddr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit ok;
        for (int i = 1; i < 4; i++) begin
            doFetch(32'h0000_0020 | (32'(i) << 11), a, ok);
            nChecks++;
            if (!ok || a !== 32'(i * 4)) begin
                nFails++;
                $display("FAIL seq_addr%0d: ok=%b addr=%h, want %h", i, ok, a, 32'(i * 4));
            end
            doRetire(0, 0, 0);
        end
        nChecks++;
        if ({fetchCount, imemAddr} !== {16'd4, 32'h10}) begin
            nFails++;
            $display("FAIL seq_count: cnt=%0d addr=%h, want 4 00000010", fetchCount, imemAddr);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        bit ok;
        doFetch(32'h1000_FFFE, a, ok);
        nChecks++;
        if (!ok || pcOut !== 32'h10) begin
            nFails++;
            $display("FAIL beq_pc: ok=%b pcOut=%h, want 00000010", ok, pcOut);
        end
        doRetire(0, 1, 1);
        nChecks++;
        if (imemAddr !== 32'h0C) begin
            nFails++;
            $display("FAIL beq_taken: addr=%h, want 0000000c", imemAddr);
        end
        doFetch(32'h0000_0000, a, ok);
        doRetire(0, 0, 0);
        doFetch(32'h1000_FFFE, a, ok);
        doRetire(0, 1, 0);
        nChecks++;
        if (imemAddr !== 32'h14) begin
            nFails++;
            $display("FAIL beq_not_taken: addr=%h, want 00000014", imemAddr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        doReset();
        doFetch(32'h1000_FFFE, a, ok);
        doRetire(0, 1, 1);
        nChecks++;
        if (imemAddr !== 32'hFFFF_FFFC) begin
            nFails++;
            $display("FAIL wrap_branch: addr=%h, want fffffffc", imemAddr);
        end
        doFetch(32'h0000_0000, a, ok);
        nChecks++;
        if (pcPlus4 !== 32'd0) begin
            nFails++;
            $display("FAIL wrap_pcplus4: pc4=%h, want 00000000", pcPlus4);
        end
        doRetire(0, 0, 0);
        nChecks++;
        if (imemAddr !== 32'd0) begin
            nFails++;
            $display("FAIL wrap_pc: addr=%h, want 00000000", imemAddr);
        end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        bit ok;
        doReset();
        doFetch(32'h0800_0040, a, ok);
        nChecks++;
        if ({pcOutB, opCodeB} !== {32'h3000_0008, 6'b000010}) begin
            nFails++;
            $display("FAIL jump_hold: pcOut=%h op=%b, want 30000008 000010", pcOutB, opCodeB);
        end
        doRetire(1, 1, 1);
        nChecks++;
        if (imemAddrB !== 32'h3000_0100) begin
            nFails++;
            $display("FAIL jump_priority: addr=%h, want 30000100", imemAddrB);
        end
        nChecks++;
        if (imemAddr !== 32'h0000_0100) begin
            nFails++;
            $display("FAIL jump_low: addr=%h, want 00000100", imemAddr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        bit ok;
        doReset();
        doFetch(32'h2008_0005, a, ok);
        for (int k = 0; k < 5; k++) begin
            imemReady = 1; imemRspValid = 1; imemRspData = $urandom; jump = 1; Branch = 1; zero = 1;
            @(negedge CLK);
            nChecks++;
            if ({instrValid, instr, pcOut, imemReq, fetchCount} !== {1'b1, 32'h2008_0005, 32'd0, 1'b0, 16'd0}) begin
                nFails++;
                $display("FAIL hold_full%0d: vld=%b instr=%h pc=%h req=%b cnt=%0d, want 1 20080005 0 0 0",
                         k, instrValid, instr, pcOut, imemReq, fetchCount);
            end
        end
        idleInputs();
        doRetire(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            imemReady = 0; imemRspValid = 1; imemRspData = $urandom;
            @(negedge CLK);
            nChecks++;
            if ({imemReq, imemAddr, instrValid} !== {1'b1, 32'd4, 1'b0}) begin
                nFails++;
                $display("FAIL hold_req%0d: req=%b addr=%h vld=%b, want 1 00000004 0", k, imemReq, imemAddr, instrValid);
            end
        end
        idleInputs();
        imemReady = 1;
        @(negedge CLK);
        imemReady = 0; consume = 1; jump = 1;
        @(negedge CLK);
        idleInputs();
        nChecks++;
        if ({imemReq, instrValid, fetchCount} !== {1'b0, 1'b0, 16'd1}) begin
            nFails++;
            $display("FAIL wait_consume: req=%b vld=%b cnt=%0d, want 0 0 1", imemReq, instrValid, fetchCount);
        end
        imemRspValid = 1; imemRspData = 32'h0000_0020;
        @(negedge CLK);
        idleInputs();
        nChecks++;
        if ({instrValid, pcOut, instr} !== {1'b1, 32'd4, 32'h0000_0020}) begin
            nFails++;
            $display("FAIL wait_resp: vld=%b pc=%h instr=%h, want 1 00000004 00000020", instrValid, pcOut, instr);
        end
        doRetire(0, 0, 0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] a;
        bit ok;
        doReset();
        for (int i = 0; i < 2; i++) begin
            doFetch(32'h0000_0020, a, ok);
            doRetire(0, 0, 0);
        end
        imemReady = 1;
        @(negedge CLK);
        imemReady = 0;
        nChecks++;
        if ({imemReq, imemAddr} !== {1'b0, 32'd8}) begin
            nFails++;
            $display("FAIL abort_wait: req=%b addr=%h, want 0 00000008", imemReq, imemAddr);
        end
        RST = 0;
        #1;
        nChecks++;
        if ({imemReq, imemAddr, instrValid, fetchCount} !== {1'b1, 32'd0, 1'b0, 16'd0}) begin
            nFails++;
            $display("FAIL abort_async: req=%b addr=%h vld=%b cnt=%0d, want 1 0 0 0", imemReq, imemAddr, instrValid, fetchCount);
        end
        @(negedge CLK);
        RST = 1;
        imemRspValid = 1; imemRspData = 32'hDEAD_BEEF;
        @(negedge CLK);
        @(negedge CLK);
        idleInputs();
        nChecks++;
        if ({imemReq, imemAddr, instrValid, instr} !== {1'b1, 32'd0, 1'b0, 32'd0}) begin
            nFails++;
            $display("FAIL stale_resp: req=%b addr=%h vld=%b instr=%h, want 1 0 0 0", imemReq, imemAddr, instrValid, instr);
        end
    endtask

    task automatic test_random();
        logic [31:0] modelPc, word;
        logic        j, b, z;
        int          cnt;
        doReset();
        modelPc = 32'd0;
        cnt = 0;
        for (int n = 0; n < 150; n++) begin
            word = $urandom;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                imemReady = 0; imemRspValid = 1'($urandom_range(0, 1)); imemRspData = $urandom;
                @(negedge CLK);
            end
            nChecks++;
            if ({imemReq, imemAddr} !== {1'b1, modelPc}) begin
                nFails++;
                $display("FAIL rnd_req%0d: req=%b addr=%h, want 1 %h", n, imemReq, imemAddr, modelPc);
            end
            imemReady = 1; imemRspValid = 0;
            @(negedge CLK);
            imemReady = 0;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                imemRspValid = 0; imemReady = 1'($urandom_range(0, 1)); consume = 1'($urandom_range(0, 1));
                jump = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            imemRspValid = 1; imemRspData = word; imemReady = 0; consume = 0; jump = 0;
            @(negedge CLK);
            imemRspValid = 0;
            nChecks++;
            if ({instrValid, instr, pcOut, pcPlus4, opCode} !== {1'b1, word, modelPc, modelPc + 32'd4, word[31:26]}) begin
                nFails++;
                $display("FAIL rnd_hold%0d: vld=%b instr=%h pc=%h pc4=%h, want 1 %h %h %h",
                         n, instrValid, instr, pcOut, pcPlus4, word, modelPc, modelPc + 32'd4);
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                imemReady = 1'($urandom_range(0, 1)); imemRspValid = 1'($urandom_range(0, 1));
                imemRspData = $urandom; jump = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            idleInputs();
            j = ($urandom_range(0, 3) == 0);
            b = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            doRetire(j, b, z);
            modelPc = refNext(modelPc, word, j, b, z);
            cnt++;
            nChecks++;
            if ({fetchCount, fetchCountB} !== {16'(cnt), 2'(cnt % 4)}) begin
                nFails++;
                $display("FAIL rnd_count%0d: cnt=%0d cntB=%0d, want %0d %0d", n, fetchCount, fetchCountB, cnt, cnt % 4);
            end
        end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_first_fetch();
        test_sequential();
        test_branch();
        test_wrap();
        test_jump();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front end of the single-cycle MIPS core. It owns the PC and fetches 32-bit words from instruction memory over a valid/ready request and response handshake. It holds one instruction for the decode stage and presents its opCode to Main_Decoder. It consumes that decoder's jump and Branch outputs, together with the ALU zero flag, to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; the first fetch address.
CNT_W, 16, width of the retired-fetch counter.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  reset, asynchronous, active-low.
imemReq  output  1  fetch request valid.
imemAddr  output  32  fetch address; equals the current PC.
imemReady  input  1  memory accepts the request this cycle.
imemRspValid  input  1  response data valid.
imemRspData  input  32  fetched instruction word.
instr  output  32  held instruction.
opCode  output  6  instr[31:26]; goes to Main_Decoder.
instrValid  output  1  instr is valid.
consume  input  1  downstream retires instr this cycle.
jump  input  1  from Main_Decoder; sampled only at consume.
Branch  input  1  from Main_Decoder; sampled only at consume.
zero  input  1  ALU zero flag; sampled only at consume.
pcOut  output  32  PC of the held instruction.
pcPlus4  output  32  pcOut + 4, modulo 2^32.
fetchCount  output  CNT_W  count of retired instructions; wraps.

Behaviour:
- Reset (RST=0, asynchronous): state goes to REQ, PC=RESET_PC, instr=0, instrValid=0, fetchCount=0. imemReq is 1 in REQ, so it is asserted from reset (see REQ). All other outputs derive from these values.
- States:
  - REQ: imemReq=1, imemAddr=PC. If imemReady=1, go to WAIT.
  - WAIT: imemReq=0. If imemRspValid=1, instr<=imemRspData and go to FULL.
  - FULL: instrValid=1. If consume=1, update PC, increment fetchCount and go to REQ.
- Only one request is outstanding at a time.
- imemRspValid is ignored in REQ and FULL. This discards a stale response that arrives after a reset.
- imemRspValid and imemReady are ignored outside the states in which they are sampled.
- consume is ignored when instrValid=0.
- Next PC, evaluated in FULL when consume=1:
  - If jump=1: PC <= {pcPlus4[31:28], instr[25:0], 2'b00}. jump has priority over Branch.
  - Else if Branch=1 and zero=1: PC <= pcPlus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), 32-bit wrap.
  - Else: PC <= pcPlus4.
- Minimum latency: 3 cycles per instruction with imemReady=1 on the first REQ cycle, a one-cycle memory response and consume=1 immediately.
- Backpressure: FULL holds instr, pcOut and instrValid stable indefinitely while consume=0.
- imemAddr is stable while imemReq=1 and imemReady=0.
- PC wraps 0xFFFF_FFFC -> 0x0000_0000 with no error.
- fetchCount wraps from all-ones to 0.
- Reset asserted in any state aborts the fetch in progress immediately. On release, fetching restarts at RESET_PC.
- Address alignment is not checked; imemAddr[1:0] is always 0 by construction.

Test Plan:
- Reset release, imemReady=1, response 0x2008_0005 one cycle later -> imemAddr=0x0 with imemReq=1; then instrValid=1, opCode=6'b001000, pcOut=0, pcPlus4=4.
- Four sequential non-control instructions with consume=1 -> imemAddr sequence 0, 4, 8, 0xC; fetchCount=4.
- pcOut=0x10, instr=0x1000_FFFE (beq), Branch=1: with zero=1 the next imemAddr is 0x0C; with zero=0 it is 0x14.
- pcOut=0x3000_0008, instr=0x0800_0040, jump=1, Branch=1 -> next imemAddr=0x3000_0100 (jump wins).
- Hold consume=0 for 5 cycles, with imemReady=0 for 3 cycles during a REQ -> instr, pcOut and imemAddr stay stable; no extra request is issued; fetchCount is unchanged.
- Assert RST in WAIT, then drive imemRspValid=1 after release -> stale response ignored; imemReq=1, imemAddr=RESET_PC, instrValid=0.
